// File: rtl/part5_serial_cmp.sv
// Digit-serial magnitude comparator: walks DIGIT-wide slices from the MSB and stops at the first difference.
// Optional signed mode is compiled in with the CMP_SIGNED_EN macro (adds input sgn).
module part5_serial_cmp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             sgn,
`endif
    output logic             busy,
    output logic             done,
    output logic             E,
    output logic             L,
    output logic             G
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [IDX_W-1:0]   r_idx;
    logic               w_sgn;
    logic [WIDTH-1:0]   w_cap_a;
    logic [WIDTH-1:0]   w_cap_b;
    logic [DIGIT-1:0]   w_a_sl;
    logic [DIGIT-1:0]   w_b_sl;
    logic               w_ne;
    logic               w_last;

`ifdef CMP_SIGNED_EN
    assign w_sgn = sgn;
`else
    assign w_sgn = 1'b0;
`endif

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign w_cap_a = {a[WIDTH-1] ^ w_sgn, a[WIDTH-2:0]};
    assign w_cap_b = {b[WIDTH-1] ^ w_sgn, b[WIDTH-2:0]};

    // Operands shift left each RUN cycle, so the slice under test is always the top DIGIT bits.
    assign w_a_sl = r_a[WIDTH-1 -: DIGIT];
    assign w_b_sl = r_b[WIDTH-1 -: DIGIT];
    assign w_ne   = (w_a_sl != w_b_sl);
    assign w_last = (r_idx == '0);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_ne || w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: operand registers are reset too; they are a few flops, not a RAM, so the cost is trivial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            E     <= 1'b1;
            L     <= 1'b0;
            G     <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_a   <= w_cap_a;
            r_b   <= w_cap_b;
            r_idx <= IDX_W'(NSLICE - 1);
        end else if (r_state == S_RUN) begin
            if (w_ne) begin
                E <= 1'b0;
                L <= (w_a_sl < w_b_sl);
                G <= (w_a_sl > w_b_sl);
            end else if (w_last) begin
                E <= 1'b1;
                L <= 1'b0;
                G <= 1'b0;
            end
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
            r_idx <= r_idx - IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_part5_serial_cmp.sv
// Self-checking bench for part5_serial_cmp: vector table, random vs. reference model, and corner sequences.
// Builds with or without CMP_SIGNED_EN.
module tb_part5_serial_cmp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start4;
    logic [7:0] a, b, a4, b4;
    logic       sgn;
    logic       busy, done, E, L, G;
    logic       busy4, done4, E4, L4, G4;

    int total = 0;
    int bad   = 0;
    bit prev_e, prev_l, prev_g;

    always #5 clk = ~clk;

    part5_serial_cmp #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef CMP_SIGNED_EN
        .sgn(sgn),
`endif
        .busy(busy), .done(done), .E(E), .L(L), .G(G)
    );

    part5_serial_cmp #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
`ifdef CMP_SIGNED_EN
        .sgn(1'b0),
`endif
        .busy(busy4), .done(done4), .E(E4), .L(L4), .G(G4)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        bit         e, l, g;
        int         lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ordering from plain integer compare, latency from the first differing digit.
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb, input bit s,
                                  input int dg, output bit e, output bit l, output bit g,
                                  output int lat);
        int n = 8 / dg;
        int mask = (1 << dg) - 1;
        if (s) begin
            l = ($signed(ma) < $signed(mb));
            g = ($signed(ma) > $signed(mb));
        end else begin
            l = (ma < mb);
            g = (ma > mb);
        end
        e   = (ma == mb);
        lat = n + 1;
        for (int k = 1; k <= n; k++) begin
            int sh = 8 - k * dg;
            if (((int'(ma) >> sh) & mask) != ((int'(mb) >> sh) & mask)) begin
                lat = k + 1;
                break;
            end
        end
    endfunction

    task automatic run_cmp(input logic [7:0] ta, input logic [7:0] tbv, input bit ts,
                           input bit e, input bit l, input bit g, input int lat,
                           input string name);
        int n;
        @(negedge clk);
        a = ta; b = tbv; sgn = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, ".busy_run"}, busy, 1'b1);
        check({name, ".hold_elg"}, {E, L, G}, {prev_e, prev_l, prev_g});
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, ".latency"}, n, lat);
        check({name, ".done"}, done, 1'b1);
        check({name, ".elg"}, {E, L, G}, {e, l, g});
        @(negedge clk);
        check({name, ".done_1cyc"}, done, 1'b0);
        check({name, ".busy_idle"}, busy, 1'b0);
        prev_e = e; prev_l = l; prev_g = g;
    endtask

    task automatic run4(input logic [7:0] ta, input logic [7:0] tbv, input bit e,
                        input bit l, input bit g, input int lat, input bit scramble,
                        input string name);
        int dn = 0;
        @(negedge clk);
        a4 = ta; b4 = tbv; start4 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (scramble && n == 1) begin
                a4 = 8'hFF; b4 = 8'h00;
            end
            if (done4 && dn == 0) dn = n;
        end
        check({name, ".latency"}, dn, lat);
        check({name, ".elg"}, {E4, L4, G4}, {e, l, g});
    endtask

    vec_t vecs[8];

    initial begin
        bit me, ml, mg;
        int mlat, dones, first_n;
        logic busy_after;
        logic [7:0] ra, rb;
        bit rs;

        vecs[0] = '{8'h00, 8'h00, 1, 0, 0, 9};
        vecs[1] = '{8'h80, 8'h7F, 0, 0, 1, 2};
        vecs[2] = '{8'h05, 8'h06, 0, 1, 0, 8};
        vecs[3] = '{8'hFF, 8'hFF, 1, 0, 0, 9};
        vecs[4] = '{8'h00, 8'hFF, 0, 1, 0, 2};
        vecs[5] = '{8'hFE, 8'hFF, 0, 1, 0, 9};
        vecs[6] = '{8'h40, 8'h00, 0, 0, 1, 3};
        vecs[7] = '{8'h12, 8'h13, 0, 1, 0, 9};

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        a = '0; b = '0; a4 = '0; b4 = '0; sgn = 1'b0;
        #12;
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.elg", {E, L, G}, 3'b100);
        check("reset.elg4", {E4, L4, G4}, 3'b100);
        prev_e = 1; prev_l = 0; prev_g = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_cmp(vecs[i].va, vecs[i].vb, 1'b0, vecs[i].e, vecs[i].l, vecs[i].g,
                    vecs[i].lat, $sformatf("vec%0d", i));

`ifdef CMP_SIGNED_EN
        run_cmp(8'h80, 8'h7F, 1'b1, 0, 1, 0, 2, "signed_80_7f");
        run_cmp(8'hFF, 8'h01, 1'b1, 0, 1, 0, 2, "signed_ff_01");
`endif

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = (i % 3 == 0) ? (ra ^ (8'h01 << $urandom_range(0, 7))) : 8'($urandom);
            if (i % 7 == 0) rb = ra;
`ifdef CMP_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rs, 1, me, ml, mg, mlat);
            run_cmp(ra, rb, rs, me, ml, mg, mlat, $sformatf("rand%0d", i));
        end

        // start pulsed in RUN and held in the DONE cycle must both be ignored.
        @(negedge clk);
        a = 8'h05; b = 8'h06; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        dones = 0; first_n = 0; busy_after = 1'bx;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == first_n + 1 && first_n != 0) busy_after = busy;
            if (done) begin
                dones++;
                if (first_n == 0) first_n = n;
                start = 1'b1;
            end
            if (n == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end
        end
        check("ignore_start.dones", dones, 1);
        check("ignore_start.latency", first_n, 8);
        check("ignore_start.elg", {E, L, G}, 3'b010);
        check("ignore_start.busy_after_done", busy_after, 1'b0);
        prev_e = 0; prev_l = 1; prev_g = 0;

        run4(8'h3C, 8'h3C, 1, 0, 0, 3, 1'b1, "d4_equal_scrambled");
        run4(8'h3C, 8'h3D, 0, 1, 0, 3, 1'b0, "d4_lsb_digit");
        run4(8'h5C, 8'h3C, 0, 0, 1, 2, 1'b0, "d4_msb_digit");

        // Abort a compare with reset in its third cycle.
        @(negedge clk);
        a = 8'h00; b = 8'h00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.done", done, 1'b0);
        check("abort.elg", {E, L, G}, 3'b100);
        @(negedge clk);
        check("abort.done_held", done, 1'b0);
        rst_n = 1'b1;
        prev_e = 1; prev_l = 0; prev_g = 0;
        run_cmp(8'h40, 8'h00, 1'b0, 0, 0, 1, 3, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
